pc_fetch_stage: RTL and testbench

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage.sv | 116 +++++++++++
 tb/tb_pc_fetch_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// ============================================================================
//  Module      : pc_fetch_stage
//  Description : Program-counter and instruction-fetch stage. Each fetch goes
//                IDLE/WAIT -> VALID, and the next PC is selected when decode
//                accepts. Define FETCH_MISALIGN_TRAP_EN to trap on a misaligned
//                fetch target. Without it, the low PC bits are forced to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic        misalign
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_WAIT  = 2'b01;
    localparam logic [1:0] S_VALID = 2'b10;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] S_TRAP  = 2'b11;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jalr_target;
    logic [31:0] w_target;

    assign w_pc_plus4    = r_pc + 32'd4;
    // JALR targets always have bit 0 cleared before any alignment check.
    assign w_jalr_target = ALUResult & 32'hFFFF_FFFE;

    always_comb begin
        w_target = w_pc_plus4;
        case (PCSrc)
            2'b01:   w_target = r_pc + ImmExt;
            2'b10:   w_target = w_jalr_target;
            default: w_target = w_pc_plus4;
        endcase
    end

`ifndef FETCH_MISALIGN_TRAP_EN
    logic [31:0] w_next_pc;
    assign w_next_pc = w_target & 32'hFFFF_FFFC;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_instr <= imem_rdata;
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (!stall) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        r_pc <= w_target;
                        if (w_target[1:0] != 2'b00) begin
                            r_state <= S_TRAP;
                        end else begin
                            r_state <= S_WAIT;
                        end
`else
                        r_pc    <= w_next_pc;
                        r_state <= S_WAIT;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                S_TRAP: r_state <= S_TRAP;
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = (r_state == S_WAIT);
    assign imem_addr   = r_pc;
    assign PC          = r_pc;
    assign PCPlus4     = w_pc_plus4;
    assign Instr       = r_instr;
    assign instr_valid = (r_state == S_VALID);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign = (r_state == S_TRAP);
`else
    assign misalign = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
// ============================================================================
//  Module      : tb_pc_fetch_stage
//  Description : Directed self-checking bench for pc_fetch_stage with a
//                scoreboard of expected {PC, Instr} pairs per fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] ImmExt = 32'h0;
    logic [31:0] ALUResult = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        misalign;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_instr = 32'h0;
    logic [63:0] sb[$];

    pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .ImmExt(ImmExt),
        .ALUResult(ALUResult), .stall(stall), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PC(PC), .PCPlus4(PCPlus4), .Instr(Instr), .instr_valid(instr_valid),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Deassert reset, then present a stray response in the IDLE cycle.
    task automatic release_rst();
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("post_rst_instr", Instr, 32'h0);
        chk1("post_rst_valid", instr_valid, 1'b0);
    endtask

    task automatic fetch(input int lat, input logic [31:0] data);
        logic [63:0] e;
        chk1("wait_req", imem_req, 1'b1);
        chk("wait_addr", imem_addr, exp_pc);
        for (int i = 1; i < lat; i++) begin
            imem_rdata = $urandom;
            tick();
            chk("wait_instr_hold", Instr, exp_instr);
            chk("wait_pc_hold", PC, exp_pc);
            chk1("wait_valid", instr_valid, 1'b0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb.push_back({exp_pc, data});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        e = sb.pop_front();
        chk1("valid_flag", instr_valid, 1'b1);
        chk1("valid_req", imem_req, 1'b0);
        chk("valid_pc", PC, e[63:32]);
        chk("valid_instr", Instr, e[31:0]);
        chk("valid_pcplus4", PCPlus4, e[63:32] + 32'd4);
        exp_instr = data;
    endtask

    task automatic advance(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] alu);
        logic [31:0] t;
        case (sel)
            2'b01:   t = exp_pc + imm;
            2'b10:   t = {alu[31:1], 1'b0};
            default: t = exp_pc + 32'd4;
        endcase
        PCSrc = sel;
        ImmExt = imm;
        ALUResult = alu;
        stall = 1'b0;
        tick();
        PCSrc = 2'($urandom);
        ImmExt = $urandom;
        ALUResult = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) begin
            exp_pc = t;
            chk1("trap_misalign", misalign, 1'b1);
            chk("trap_pc", PC, t);
            chk1("trap_valid", instr_valid, 1'b0);
            chk1("trap_req", imem_req, 1'b0);
            return;
        end
`endif
        exp_pc = t & 32'hFFFF_FFFC;
        chk("adv_pc", PC, exp_pc);
        chk1("adv_req", imem_req, 1'b1);
        chk1("adv_valid", instr_valid, 1'b0);
        chk1("adv_misalign", misalign, 1'b0);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
        release_rst();

        // Sequential fetch, 1-cycle memory
        fetch(1, 32'h0050_0093);
        advance(2'b00, 32'h0, 32'h0);
        fetch(1, 32'h0050_0093);
        advance(2'b00, 32'h0, 32'h0);
        chk("seq_pc8", PC, 32'h8);
        fetch(2, 32'h00A0_0113);

        // Branch forward/backward
        advance(2'b01, 32'h8, 32'h0);
        fetch(1, 32'h1111_1111);
        advance(2'b01, 32'hFFFF_FFF8, 32'h0);
        chk("branch_back_addr", imem_addr, 32'h8);
        fetch(3, 32'h2222_2222);
        advance(2'b01, 32'h8, 32'h0);
        fetch(1, 32'h3333_3333);

        // Stall with spurious responses and toggling control inputs
        for (int i = 0; i < 5; i++) begin
            stall = 1'b1;
            PCSrc = 2'b01;
            ImmExt = 32'h100;
            imem_rvalid = 1'b1;
            imem_rdata = $urandom;
            tick();
            chk("stall_pc", PC, exp_pc);
            chk("stall_instr", Instr, exp_instr);
            chk1("stall_req", imem_req, 1'b0);
            chk1("stall_valid", instr_valid, 1'b1);
        end
        imem_rvalid = 1'b0;
        advance(2'b00, 32'h0, 32'h0);
        chk("stall_release_pc", PC, 32'h14);
        fetch(4, 32'h4444_4444);

        // JALR with bit 0 set from PC=0x10
        advance(2'b01, 32'hFFFF_FFFC, 32'h0);
        fetch(1, 32'h5555_5555);
        advance(2'b10, 32'h0, 32'h0000_0103);
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (2) tick();
        chk1("trap_hold", misalign, 1'b1);
        chk("trap_hold_pc", PC, 32'h102);
`else
        chk("jalr_pc", PC, 32'h100);
        fetch(1, 32'h6666_6666);
        advance(2'b10, 32'h0, 32'h0000_0041);
        chk("pre_rst_addr", imem_addr, 32'h40);
        chk1("pre_rst_req", imem_req, 1'b1);
`endif

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("async_pc", PC, 32'h0);
        chk1("async_req", imem_req, 1'b0);
        chk1("async_valid", instr_valid, 1'b0);
        chk1("async_misalign", misalign, 1'b0);
        chk("async_instr", Instr, 32'h0);
        tick();
        exp_pc = 32'h0;
        exp_instr = 32'h0;
        release_rst();
        fetch(1, 32'h7777_7777);

        // Wrap-around at the top of the address space
        advance(2'b10, 32'h0, 32'hFFFF_FFFC);
        fetch(1, 32'h8888_8888);
        chk("wrap_pcplus4", PCPlus4, 32'h0);
        advance(2'b00, 32'h0, 32'h0);
        chk("wrap_pc", PC, 32'h0);
        fetch(1, 32'h9999_9999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
